map_engine: RTL

Parametrised successor to the per-level map blocks. It holds a table of static terrain rectangles plus `NUM_LIFTS` button-driven moving platforms ("lifts"), and turns the VGA scan position into a registered sprite-ROM address. It sits between the VGA controller and the shared 320-wide sprite ROM, beside `obj_state_ctrl`, which supplies the lift button signals. Lift positions are also exported so collision logic can follow the moving platforms.

---
 rtl/map_pkg.sv | 28 ++
 rtl/lift_ctrl.sv | 53 +++++
 rtl/map_engine.sv | 114 +++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// map_pkg: shared object geometry, lift states and layout tables for map_engine.
package map_pkg;
  localparam int V_ACTIVE = 480;
  localparam int OFF_W = 6;
  typedef struct packed {
    logic [9:0] ph;
    logic [9:0] pv;
    logic [9:0] w;
    logic [9:0] ht;
    logic [9:0] mh;
    logic [9:0] mv;
  } obj_rect_t;
  typedef enum logic [1:0] {DOWN, RISING, UP, FALLING} lift_state_t;
  localparam obj_rect_t WALL_TABLE [0:7] = '{
    '{10'd10,  10'd0,   10'd20, 10'd240, 10'd50,  10'd215},
    '{10'd100, 10'd150, 10'd60, 10'd20,  10'd0,   10'd0},
    '{10'd200, 10'd200, 10'd80, 10'd10,  10'd0,   10'd20},
    '{10'd40,  10'd220, 10'd40, 10'd20,  10'd100, 10'd0},
    '{10'd250, 10'd50,  10'd30, 10'd30,  10'd10,  10'd30},
    '{10'd150, 10'd20,  10'd20, 10'd20,  10'd60,  10'd60},
    '{10'd290, 10'd100, 10'd20, 10'd60,  10'd0,   10'd80},
    '{10'd60,  10'd100, 10'd20, 10'd20,  10'd30,  10'd100}
  };
  localparam obj_rect_t LIFT_TABLE [0:1] = '{
    '{10'd120, 10'd160, 10'd30, 10'd8, 10'd200, 10'd0},
    '{10'd200, 10'd100, 10'd30, 10'd8, 10'd200, 10'd10}
  };
endpackage

// File: rtl/lift_ctrl.sv
// lift_ctrl: per-lift frame prescaler, DOWN/RISING/UP/FALLING FSM and offset counter.
// Only built when MAP_ENGINE_LIFT_EN is defined.
`ifdef MAP_ENGINE_LIFT_EN
module lift_ctrl import map_pkg::*; #(
  parameter int LIFT_TRAVEL = 40,
  parameter int LIFT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             btn,
  output logic [OFF_W-1:0] offset,
  output logic             moving
);
  localparam logic [OFF_W-1:0] TOP = OFF_W'(LIFT_TRAVEL);
  lift_state_t state, state_nx;
  logic [15:0] cnt;
  logic [OFF_W-1:0] offset_nx;
  logic step;
  assign step = tick && en && cnt == 16'(LIFT_DIV - 1);
  assign moving = state == RISING || state == FALLING;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      state <= DOWN;
      offset <= '0;
    end else begin
      if (tick && en) cnt <= step ? '0 : cnt + 16'd1;
      if (step) begin
        state <= state_nx;
        offset <= offset_nx;
      end
    end
  // a direction change consumes its step without moving the offset
  always_comb begin
    state_nx = state;
    offset_nx = offset;
    case (state)
      DOWN: state_nx = btn ? RISING : DOWN;
      RISING: begin
        state_nx = !btn ? FALLING : (offset >= TOP - 6'd1 ? UP : RISING);
        offset_nx = !btn ? offset : (offset >= TOP ? TOP : offset + 6'd1);
      end
      UP: state_nx = btn ? UP : FALLING;
      FALLING: begin
        state_nx = btn ? RISING : (offset <= 6'd1 ? DOWN : FALLING);
        offset_nx = btn || offset == '0 ? offset : offset - 6'd1;
      end
    endcase
  end
endmodule
`endif

// File: rtl/map_engine.sv
// map_engine: 2-stage scan-position to sprite-ROM address mapper for static walls and moving lifts.
// Lifts are built only when MAP_ENGINE_LIFT_EN is defined; otherwise only walls render.
module map_engine import map_pkg::*; #(
  parameter int NUM_WALLS = 8,
  parameter int NUM_LIFTS = 2,
  parameter int LIFT_TRAVEL = 40,
  parameter int LIFT_DIV = 2,
  parameter int BG_ADDR = 12900,
  parameter int ROM_W = 320
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [9:0]                 vga_h,
  input  logic [9:0]                 vga_v,
  input  logic [NUM_LIFTS-1:0]       lift_btn,
  output logic [16:0]                addr,
  output logic                       hit,
  output logic [NUM_LIFTS*OFF_W-1:0] lift_offset,
  output logic [NUM_LIFTS-1:0]       lift_moving
);
  logic [9:0] h, v, h_q, v_q, sel_ph, sel_pv, sel_mh, sel_mv;
  logic [NUM_WALLS-1:0] wall_hit, wall_q;
  logic [NUM_LIFTS-1:0] lift_hit, lift_q;
  logic [NUM_LIFTS*OFF_W-1:0] off;
  logic [OFF_W-1:0] sel_off;
  logic [16:0] col, row, addr_nx;
  logic any;
  logic unused_bits;
  assign h = {1'b0, vga_h[9:1]};
  assign v = {1'b0, vga_v[9:1]};
  for (genvar i = 0; i < NUM_WALLS; i++) begin : g_wall
    assign wall_hit[i] = h >= WALL_TABLE[i].ph && 11'(h) < 11'(WALL_TABLE[i].ph) + 11'(WALL_TABLE[i].w) &&
                         v >= WALL_TABLE[i].pv && 11'(v) < 11'(WALL_TABLE[i].pv) + 11'(WALL_TABLE[i].ht);
  end
`ifdef MAP_ENGINE_LIFT_EN
  logic at_tick, tick_flag, tick;
  assign at_tick = vga_v == 10'(V_ACTIVE) && vga_h == '0;
  assign tick = at_tick && !tick_flag;
  assign off = lift_offset;
  assign unused_bits = ^{vga_h[0], vga_v[0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) tick_flag <= 1'b0;
    else tick_flag <= at_tick;
  for (genvar i = 0; i < NUM_LIFTS; i++) begin : g_lift
    logic [10:0] pv_eff, dv;
    lift_ctrl #(.LIFT_TRAVEL(LIFT_TRAVEL), .LIFT_DIV(LIFT_DIV)) u_lift (
      .clk(clk), .rst(rst), .en(en), .tick(tick), .btn(lift_btn[i]),
      .offset(lift_offset[i*OFF_W +: OFF_W]), .moving(lift_moving[i])
    );
    // 11-bit two's complement: bit 10 set means the lift top is above row 0 or the pixel is above the lift
    assign pv_eff = 11'(LIFT_TABLE[i].pv) - 11'(off[i*OFF_W +: OFF_W]);
    assign dv = 11'(v) - pv_eff;
    assign lift_hit[i] = h >= LIFT_TABLE[i].ph && 11'(h) < 11'(LIFT_TABLE[i].ph) + 11'(LIFT_TABLE[i].w) &&
                         !pv_eff[10] && !dv[10] && dv < 11'(LIFT_TABLE[i].ht);
  end
`else
  assign off = '0;
  assign lift_offset = '0;
  assign lift_moving = '0;
  assign lift_hit = '0;
  assign unused_bits = ^{vga_h[0], vga_v[0], lift_btn};
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
      wall_q <= '0;
      lift_q <= '0;
    end else begin
      h_q <= h;
      v_q <= v;
      wall_q <= wall_hit;
      lift_q <= lift_hit;
    end
  // descending scans so the lowest index wins, lifts applied last so they beat walls
  always_comb begin
    sel_ph = '0;
    sel_pv = '0;
    sel_mh = '0;
    sel_mv = '0;
    sel_off = '0;
    any = 1'b0;
    for (int k = NUM_WALLS - 1; k >= 0; k--)
      if (wall_q[k]) begin
        sel_ph = WALL_TABLE[k].ph;
        sel_pv = WALL_TABLE[k].pv;
        sel_mh = WALL_TABLE[k].mh;
        sel_mv = WALL_TABLE[k].mv;
        sel_off = '0;
        any = 1'b1;
      end
    for (int k = NUM_LIFTS - 1; k >= 0; k--)
      if (lift_q[k]) begin
        sel_ph = LIFT_TABLE[k].ph;
        sel_pv = LIFT_TABLE[k].pv;
        sel_mh = LIFT_TABLE[k].mh;
        sel_mv = LIFT_TABLE[k].mv;
        sel_off = off[k*OFF_W +: OFF_W];
        any = 1'b1;
      end
  end
  assign col = 17'(h_q) - 17'(sel_ph) + 17'(sel_mh);
  assign row = 17'(v_q) - 17'(sel_pv) + 17'(sel_off) + 17'(sel_mv);
  assign addr_nx = col + row * 17'(ROM_W);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= 17'(BG_ADDR);
      hit <= 1'b0;
    end else begin
      addr <= en && any ? addr_nx : 17'(BG_ADDR);
      hit <= en && any;
    end
endmodule
